stall_pipeline_n: RTL
=====================

# stall_pipeline_n

Parametrised N-stage stall/flush pipeline that carries DATA_W-bit beats from the upstream producer to the shared resource through an arbiter request/grant handshake, and registers resource results to the consumer. Each stage holds one beat. Backpressure propagates as a bubble-collapsing ready chain, so stalls compress gaps instead of freezing the whole pipe. A credit counter caps the number of beats in flight at the resource. The block is the generalised successor of the fixed 3-stage, 32-bit pipeline: it gains a valid-gated request, a credit limit, and occupancy/outstanding status.

## Interface
- DATA_W, 32, beat width (>=1)
- DEPTH, 3, number of pipeline stages (>=1)
- MAX_OUTSTANDING, 4, maximum beats issued to the resource and not yet returned (>=1)
- CNT_W, $clog2(DEPTH+1), width of out_occupancy (derived)
- OUT_W, $clog2(MAX_OUTSTANDING+1), width of out_outstanding (derived)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- inputs  in  DATA_W  producer beat
- in_valid  in  1  producer beat valid
- in_flush  in  1  kill all beats held in the pipeline stages
- arbiter_grant  in  1  resource grant for this cycle
- resource_output  in  DATA_W  result from the resource
- in_valid_from_resource  in  1  result valid (no backpressure)
- pipeline_output  out  DATA_W  registered result to the consumer
- out_valid_to_consumer  out  1  pipeline_output valid
- resource_input  out  DATA_W  last-stage data
- out_valid_to_resource  out  1  last-stage valid
- arbiter_req  out  1  request to the arbiter
- out_stall  out  1  upstream must hold; the beat is not accepted
- out_occupancy  out  CNT_W  number of valid stages
- out_outstanding  out  OUT_W  issued-but-unreturned count

## Operation
- Stage k holds registers v[k] and d[k]. Stage 0 is fed by inputs; stage DEPTH-1 drives the resource. Data passes through each stage unmodified.
- credit_full = (outstanding == MAX_OUTSTANDING).
- rdy[DEPTH-1] = arbiter_grant & ~credit_full.
- rdy[k] = ~v[k+1] | rdy[k+1], combinational.
- Stage k loads when ~v[k] | rdy[k]:
  - stage 0 loads {in_valid, inputs};
  - stage k>0 loads {v[k-1], d[k-1]}.
- A stage that is not loading holds its contents.
- out_stall = v[0] & ~rdy[0].
- A producer beat is accepted when in_valid & ~out_stall.
- arbiter_req = out_valid_to_resource = v[DEPTH-1] & ~credit_full.
- resource_input = d[DEPTH-1].
- A transfer (issue) occurs when v[DEPTH-1] & arbiter_req & arbiter_grant.
- outstanding update:
  - +1 on issue;
  - -1 on in_valid_from_resource when outstanding > 0;
  - issue and return in the same cycle: unchanged;
  - a return while outstanding == 0 is ignored, and the counter stays at 0.
- Flush: when in_flush is high, all v[k] are 0 next cycle and the producer beat offered in that cycle is dropped. An issue that completes in the flush cycle still counts and is not retracted. outstanding and the return path are unaffected by flush.
- Return path: pipeline_output and out_valid_to_consumer are registered copies of resource_output and in_valid_from_resource. pipeline_output is updated only when the valid is high.
- out_occupancy = popcount(v), registered-consistent with the stage valids.

## Timing
- Reset values:
  - all v[k] = 0 and d[k] = 0;
  - outstanding = 0;
  - pipeline_output = 0 and out_valid_to_consumer = 0;
  - consequently arbiter_req = out_valid_to_resource = out_stall = 0, out_occupancy = 0, resource_input = 0.
- Reset has priority over flush and over all other inputs.
- Latency with no stalls: a beat accepted at edge t is presented on resource_input with out_valid_to_resource at cycle t+DEPTH.
- Throughput: one beat per cycle while grant is held high and credit is available.
- Bubble collapse: an empty stage always loads, even when downstream is stalled.
- A full pipe with no grant asserts out_stall the same cycle.
- Credit boundary: at outstanding == MAX_OUTSTANDING, req drops combinationally. If a return arrives in that cycle, req reasserts on the next cycle (not the same cycle).
- Return latency: 1 cycle from in_valid_from_resource to out_valid_to_consumer.
- DEPTH = 1: the single stage is both input and output; the rules above still hold.

## Test plan
- Streaming: DEPTH=3, grant held high, inputs 1,2,3,4 on consecutive cycles. Expected: resource_input shows 1..4 on cycles 3..6 with req high, out_stall never asserted.
- Full stall: grant low, feed 4 beats. Expected:
  - out_occupancy reaches 3 and out_stall=1 on the 4th beat, which is held;
  - when grant rises for 1 cycle, exactly one beat issues, out_stall drops, and the held beat is accepted.
- Bubble collapse: feed A, idle, B with grant low. Expected: stages end with B in stage 1 and A in stage 2; occupancy 2.
- Credit limit: MAX_OUTSTANDING=2, grant high, no returns. Expected:
  - after 2 issues, outstanding=2 and arbiter_req=0 with v[DEPTH-1]=1;
  - a return restores req next cycle;
  - simultaneous issue+return leaves the count unchanged.
- Flush: fill 3 stages, assert in_flush with grant high. Expected: the last beat issues, all valids clear next cycle, outstanding keeps the issued beat.
- Reset mid-operation: full pipe with outstanding=2 and a return in flight, then assert reset. Expected: every output is 0 next cycle.

Source files
------------

// File: rtl/stall_pipeline_n.sv
// stall_pipeline_n
// ----------------------------------------------------------------------------
// Purpose:
//   An N-stage pipeline with stall and flush. It carries DATA_W-bit beats from
//   an upstream producer to a shared resource, using an arbiter request/grant
//   handshake. Backpressure travels back through a bubble-collapsing ready
//   chain, so an empty stage always accepts a beat even when the stages below
//   it are stalled. A credit counter limits how many beats can be at the
//   resource at once. Results coming back from the resource are registered
//   and passed to the consumer.
//
// Ports:
//   clk                    in   single clock, rising edge
//   reset                  in   synchronous, active-high
//   inputs                 in   producer beat (DATA_W)
//   in_valid               in   producer beat valid
//   in_flush               in   kill all beats held in the stages
//   arbiter_grant          in   resource grant for this cycle
//   resource_output        in   result from the resource (DATA_W)
//   in_valid_from_resource in   result valid (no backpressure)
//   pipeline_output        out  registered result to the consumer (DATA_W)
//   out_valid_to_consumer  out  pipeline_output valid
//   resource_input         out  last-stage data (DATA_W)
//   out_valid_to_resource  out  last-stage valid, gated by credit
//   arbiter_req            out  request to the arbiter
//   out_stall              out  upstream must hold, beat not accepted
//   out_occupancy          out  number of valid stages (CNT_W)
//   out_outstanding        out  issued-but-unreturned count (OUT_W)
// ----------------------------------------------------------------------------
module stall_pipeline_n #(
  parameter int DATA_W          = 32,
  parameter int DEPTH           = 3,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CNT_W          = $clog2(DEPTH + 1),
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] inputs,
  input  logic              in_valid,
  input  logic              in_flush,
  input  logic              arbiter_grant,
  input  logic [DATA_W-1:0] resource_output,
  input  logic              in_valid_from_resource,
  output logic [DATA_W-1:0] pipeline_output,
  output logic              out_valid_to_consumer,
  output logic [DATA_W-1:0] resource_input,
  output logic              out_valid_to_resource,
  output logic              arbiter_req,
  output logic              out_stall,
  output logic [CNT_W-1:0]  out_occupancy,
  output logic [OUT_W-1:0]  out_outstanding
);

  logic [DEPTH-1:0]  r_v;
  logic [DATA_W-1:0] r_d [DEPTH];
  logic [OUT_W-1:0]  r_outstanding;
  logic [DATA_W-1:0] r_pipeOut;
  logic              r_outValid;

  logic              w_creditFull;
  logic              w_req;
  logic              w_issue;
  logic              w_retTake;
  logic [DEPTH-1:0]  w_rdy;
  logic [DEPTH-1:0]  w_load;
  logic [CNT_W-1:0]  w_occupancy;

  // The credit limit gates the request. Because of this, a return that
  // arrives while the counter is full only reopens the request on the
  // following cycle, once the counter register has actually dropped.
  assign w_creditFull = (r_outstanding == OUT_W'(MAX_OUTSTANDING));
  assign w_req        = r_v[DEPTH-1] & ~w_creditFull;
  assign w_issue      = w_req & arbiter_grant;
  assign w_retTake    = in_valid_from_resource & (r_outstanding != '0);

  // The ready chain is evaluated from the resource end back to stage 0.
  // A stage is ready to pass its beat on when the stage after it is empty
  // or is itself moving. The running term is kept in a local variable so
  // that w_rdy never reads itself.
  always_comb begin
    logic acc;
    acc             = arbiter_grant & ~w_creditFull;
    w_rdy           = '0;
    w_rdy[DEPTH-1]  = acc;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      acc      = ~r_v[k+1] | acc;
      w_rdy[k] = acc;
    end
    w_load = ~r_v | w_rdy;
  end

  // Occupancy is the count of set stage valids, taken straight from the
  // stage registers.
  always_comb begin
    w_occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occupancy = w_occupancy + CNT_W'(r_v[k]);
    end
  end

  // Stage registers. A stage that is loading takes the beat from the stage
  // above it (stage 0 takes the producer). A stage that is not loading
  // keeps what it holds. A flush clears every valid, which also drops the
  // producer beat offered in that cycle. Data is allowed to keep moving
  // during a flush, because no valid will ever qualify it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_d[k] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_v[0] <= in_valid;
        r_d[0] <= inputs;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (w_load[k]) begin
          r_v[k] <= r_v[k-1];
          r_d[k] <= r_d[k-1];
        end
      end
      if (in_flush) begin
        r_v <= '0;
      end
    end
  end

  // Outstanding credit counter. An issue and a return in the same cycle
  // cancel each other out. A return that arrives with nothing outstanding
  // is ignored. A flush does not touch this counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= '0;
    end else begin
      case ({w_issue, w_retTake})
        2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Return path. The result valid is registered every cycle. The result
  // data is only captured when that valid is high, so the consumer keeps
  // seeing the last real result in between returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outValid <= 1'b0;
      r_pipeOut  <= '0;
    end else begin
      r_outValid <= in_valid_from_resource;
      if (in_valid_from_resource) begin
        r_pipeOut <= resource_output;
      end
    end
  end

  assign pipeline_output       = r_pipeOut;
  assign out_valid_to_consumer = r_outValid;
  assign resource_input        = r_d[DEPTH-1];
  assign out_valid_to_resource = w_req;
  assign arbiter_req           = w_req;
  assign out_stall             = r_v[0] & ~w_rdy[0];
  assign out_occupancy         = w_occupancy;
  assign out_outstanding       = r_outstanding;

endmodule
